st_mem_responder: RTL
=====================

ST_MEM_RESPONDER -- requirements
Module: st_mem_responder

Interface
REQ-001 Parameter STACK_BASE, default 16'hFF00, lowest data-memory address served by the stack window.
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of stack-window depth in 16-bit words (256).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_force  input  1  stack-unit transfer request valid; high for the whole PUSH/POP burst.
REQ-006 dmem_wr  input  1  1 = write (PUSH), 0 = read (POP); sampled with mem_force.
REQ-007 dmem_addr  input  16  word address of current transfer.
REQ-008 wdata  input  16  register data to push.
REQ-009 rdest_addr  input  3  destination register of a POP beat.
REQ-010 pc_pop  input  1  POP beat targets PC instead of register file.
REQ-011 rdata  output  16  popped data, valid when RF_wr or PC_wr is high.
REQ-012 rf_addr  output  3  register-file write address, aligned with RF_wr.
REQ-013 RF_wr  output  1  one-cycle register-file write strobe.
REQ-014 PC_wr  output  1  one-cycle PC write strobe.
REQ-015 stack_fault  output  1  sticky: access outside window.
REQ-016 burst_len  output  4  beats in last completed burst.
REQ-017 burst_done  output  1  one-cycle pulse at burst end.

Function
REQ-018 Window hit when STACK_BASE <= dmem_addr < STACK_BASE + 2^DEPTH_LOG2; index = dmem_addr - STACK_BASE, DEPTH_LOG2 bits.
REQ-019 States IDLE, BURST, FAULT; IDLE->BURST on mem_force, BURST->IDLE on mem_force low, any->FAULT on out-of-window beat.
REQ-020 Each cycle mem_force is high in IDLE or BURST is one beat; writes commit at that edge.
REQ-021 Read latency exactly 1 cycle: RF_wr (pc_pop=0) or PC_wr (pc_pop=1) asserts the cycle after the beat with rdata and registered rdest_addr.
REQ-022 RF_wr and PC_wr never both high; both low for write beats and idle cycles.
REQ-023 Read of the index written in the immediately preceding cycle returns the new data (write-to-read bypass).
REQ-024 Beat counter increments per beat, saturates at 15; on falling edge of mem_force, burst_len loads counter and burst_done pulses one cycle, counter clears.
REQ-025 Back-to-back bursts (mem_force low exactly one cycle) both complete with separate burst_done pulses.
REQ-026 Out-of-window beat: no memory write, no RF_wr/PC_wr, stack_fault sets, state FAULT; FAULT ignores mem_force until reset.
REQ-027 Address wrap: index arithmetic never wraps into window; STACK_BASE + 2^DEPTH_LOG2 is a fault even if 16-bit sum overflows (compare with 17-bit width).
REQ-028 A POP read pending at the edge where reset asserts is discarded: no strobe follows.

Reset
REQ-029 On reset: state IDLE, rdata 0, rf_addr 0, RF_wr 0, PC_wr 0, stack_fault 0, burst_len 0, burst_done 0, beat counter 0.
REQ-030 Stack RAM contents are not reset; reading unwritten locations returns undefined data.

Structure
REQ-031 Shared package holds state enum, STACK_BASE default, DEPTH_LOG2 default and burst_len width constant.
REQ-032 Storage is one sub-module st_stack_ram: single-port synchronous 2^DEPTH_LOG2 x 16 RAM, 1-cycle read, write-first not required (bypass lives in responder).

Verification
REQ-033 Push 3 beats 0xFFFD..0xFFFF data 0x1111/0x2222/0x3333 -> no strobes, burst_done with burst_len 3.
REQ-034 Pop 0xFFFF rdest 5 then 0xFFFE pc_pop=1 -> RF_wr rf_addr 5 rdata 0x3333, next cycle PC_wr rdata 0x2222.
REQ-035 Write 0xFF10=0xABCD then read 0xFF10 next cycle -> rdata 0xABCD via bypass.
REQ-036 Beat at 0xFEFF -> stack_fault=1, no RF_wr, later requests ignored until reset clears fault.
REQ-037 Reset asserted the cycle after a POP beat -> no RF_wr/PC_wr, all outputs 0.
REQ-038 18-beat burst -> burst_len saturates at 15, single burst_done.

Source files
------------

// File: rtl/st_mem_responder_pkg.sv
// Shared definitions for the stack-window memory responder: FSM states,
// default window placement and the beat-counter width.
package st_mem_responder_pkg;

  localparam logic [15:0] STACK_BASE_DEF = 16'hFF00;
  localparam int          DEPTH_LOG2_DEF = 8;
  localparam int          BURST_LEN_W    = 4;
  localparam logic [BURST_LEN_W-1:0] BEAT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Window membership is evaluated in 17 bits so that a window ending at
  // 0x10000 does not wrap around and admit low addresses.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int          depth_log2);
    logic [16:0] a;
    logic [16:0] lo;
    logic [16:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (17'd1 << depth_log2);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/st_stack_ram.sv
// Single-port synchronous stack RAM, one-cycle read latency.
// Contents are deliberately not reset.
module st_stack_ram
  import st_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // One access per enabled cycle: either commit a write or register a read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/st_mem_responder.sv
// Stack-window responder: serves PUSH/POP bursts from the stack unit into a
// private RAM, returns POP data as register-file or PC write strobes, counts
// beats per burst and latches a sticky fault on any out-of-window beat.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no burst in progress; a mem_force beat starts one
//   ST_BURST | burst in progress; mem_force low ends it and reports length
//   ST_FAULT | out-of-window beat seen; all requests ignored until reset
module st_mem_responder
  import st_mem_responder_pkg::*;
#(
  parameter logic [15:0] STACK_BASE = STACK_BASE_DEF,
  parameter int          DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_force,
  input  logic                   dmem_wr,
  input  logic [15:0]            dmem_addr,
  input  logic [15:0]            wdata,
  input  logic [2:0]             rdest_addr,
  input  logic                   pc_pop,
  output logic [15:0]            rdata,
  output logic [2:0]             rf_addr,
  output logic                   RF_wr,
  output logic                   PC_wr,
  output logic                   stack_fault,
  output logic [BURST_LEN_W-1:0] burst_len,
  output logic                   burst_done
);

  state_t state;
  state_t state_nxt;

  logic                   hit;
  logic                   beat;
  logic                   fault_beat;
  logic                   burst_end;
  logic                   good_beat;
  logic                   wr_beat;
  logic                   rd_beat;
  logic [DEPTH_LOG2-1:0]  idx;

  logic                   rd_pend;
  logic                   rd_pc;
  logic [2:0]             rd_dest;
  logic                   byp_sel;
  logic [15:0]            byp_data;
  logic [15:0]            ram_rdata;

  logic                   last_wr_valid;
  logic [DEPTH_LOG2-1:0]  last_idx;
  logic [15:0]            last_data;

  logic [BURST_LEN_W-1:0] beat_cnt;
  logic [BURST_LEN_W-1:0] burst_len_q;
  logic                   burst_done_q;
  logic                   fault_q;

  assign hit = in_window(dmem_addr, STACK_BASE, DEPTH_LOG2);
  // For any hit the low bits of the difference are the exact window index.
  assign idx = dmem_addr[DEPTH_LOG2-1:0] - STACK_BASE[DEPTH_LOG2-1:0];

  // Next-state and beat classification.
  always_comb begin
    state_nxt  = state;
    beat       = 1'b0;
    fault_beat = 1'b0;
    burst_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_force) begin
          beat = 1'b1;
          if (!hit) begin
            fault_beat = 1'b1;
            state_nxt  = ST_FAULT;
          end else begin
            state_nxt  = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (mem_force) begin
          beat = 1'b1;
          if (!hit) begin
            fault_beat = 1'b1;
            state_nxt  = ST_FAULT;
          end
        end else begin
          burst_end = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reset has priority so a beat coinciding with reset touches nothing.
  assign good_beat = beat & hit & ~reset;
  assign wr_beat   = good_beat & dmem_wr;
  assign rd_beat   = good_beat & ~dmem_wr;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  st_stack_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (16)
  ) u_ram (
    .clk   (clk),
    .en    (good_beat),
    .we    (dmem_wr),
    .addr  (idx),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  // Remember the most recent write so a read of the same index in the very
  // next beat is served from here rather than relying on RAM write ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr_valid <= 1'b0;
      last_idx      <= '0;
      last_data     <= '0;
    end else begin
      last_wr_valid <= wr_beat;
      if (wr_beat) begin
        last_idx  <= idx;
        last_data <= wdata;
      end
    end
  end

  // POP pipeline: capture destination and bypass decision alongside the RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_pc    <= 1'b0;
      rd_dest  <= '0;
      byp_sel  <= 1'b0;
      byp_data <= '0;
    end else begin
      rd_pend <= rd_beat;
      if (rd_beat) begin
        rd_pc    <= pc_pop;
        rd_dest  <= rdest_addr;
        byp_sel  <= last_wr_valid && (last_idx == idx);
        byp_data <= last_data;
      end
    end
  end

  // Beat counter and burst completion report.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt     <= '0;
      burst_len_q  <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= burst_end;
      if (burst_end) begin
        burst_len_q <= beat_cnt;
        beat_cnt    <= '0;
      end else if (beat && (beat_cnt != BEAT_MAX)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Sticky fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (fault_beat) begin
      fault_q <= 1'b1;
    end
  end

  // Strobes are masked during reset so a POP pending as reset arrives is dropped.
  assign RF_wr       = rd_pend & ~rd_pc & ~reset;
  assign PC_wr       = rd_pend &  rd_pc & ~reset;
  assign rdata       = (RF_wr | PC_wr) ? (byp_sel ? byp_data : ram_rdata) : 16'h0000;
  assign rf_addr     = reset ? 3'd0 : rd_dest;
  assign stack_fault = fault_q;
  assign burst_len   = burst_len_q;
  assign burst_done  = burst_done_q;

endmodule
